led_chaser_n: RTL
=================

Name: led_chaser_n

Overview:
- Parametrised successor to the fixed 7-LED running-light block.
- Drives N_LEDS outputs as a vector and offers four selectable patterns: rotate left, rotate right, bounce, and bar fill.
- Step rate comes from a programmable prescaler, with a run/hold enable.
- Sits directly between the board clock/reset and the LED pins; provides step and wrap strobes for higher-level sequencing.

Parameters:
- N_LEDS, 7, number of LED outputs; legal range 2..32.
- DIV_W, 8, width of the prescaler divide input.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  reset, asynchronous, active-low; assertion clears state immediately, release is sampled on clk.
- en  input  1  1 = run; 0 = hold the prescaler and pattern frozen.
- mode  input  2  pattern select: 00 rotate left, 01 rotate right, 10 bounce, 11 bar fill.
- div  input  DIV_W  step period is div+1 clk cycles.
- led  output  N_LEDS  LED drive, registered; bit 0 is the first LED.
- step  output  1  one-cycle pulse, registered, in the cycle led takes a new pattern value.
- wrap  output  1  one-cycle pulse, registered, when led returns to the mode's start pattern after a tick.

Behaviour:
- Reset (rst=0):
  - led = 1 (led[0] lit), step = 0, wrap = 0.
  - Prescaler count cnt = 0, registered mode mode_q = 00, bounce direction dir = up, fill level = 0.
- Start patterns:
  - 00: led[0] lit only.
  - 01: led[N_LEDS-1] lit only.
  - 10: led[0] lit, dir = up.
  - 11: all LEDs off (fill level 0).
- Mode change takes priority over everything else, including en=0. When mode != mode_q on a clock edge:
  - mode_q <= mode; led <= start pattern of the new mode; cnt <= 0; dir <= up; fill level <= 0.
  - No tick, step = 0, wrap = 0 in that cycle.
- Prescaler (mode == mode_q):
  - If en=0: cnt, led and dir hold; step = 0, wrap = 0.
  - If en=1 and cnt >= div: tick. cnt <= 0 and the pattern advances.
  - If en=1 and cnt < div: cnt <= cnt+1.
  - The >= compare makes a mid-count reduction of div take effect on the next cycle without overrun.
  - div = 0 gives one tick per clock.
- Pattern advance, one per tick:
  - 00: rotate left by 1; led[N_LEDS-1] wraps to led[0]. Period N_LEDS ticks.
  - 01: rotate right by 1; led[0] wraps to led[N_LEDS-1]. Period N_LEDS ticks.
  - 10: single lit LED moves up while dir = up. On reaching led[N_LEDS-1], dir flips and the next tick goes to led[N_LEDS-2]. It moves down to led[0] and flips again. End positions are never repeated. Period 2*N_LEDS-2 ticks.
  - 11: fill level goes 0,1,..,N_LEDS and then back to 0. led = thermometer code, with the low `level` bits set. Period N_LEDS+1 ticks.
- Strobes:
  - step = 1 in the cycle after each tick edge, aligned with the new led value.
  - wrap = 1 alongside step when the new led equals the start pattern for the current mode.
  - Both are 0 on mode-change cycles.
- The one-hot modes always keep exactly one LED lit; no all-zero or multi-hot state is reachable.
- rst asserted mid-pattern: asynchronous return to reset values regardless of clk. After release, the first edge with mode != 00 performs a mode-change reload.

Test Plan:
- Reset with N_LEDS=7, mode=00, div=0, en=1: drop rst mid-run between edges -> led=7'b0000001, step=0, wrap=0 immediately. After release, sequence is 0000010, 0000100, ..., 1000000, 0000001, with wrap=1 only on the 7th tick.
- mode=01, div=1, en=1 (after reset, so a reload occurs) -> led=1000000 on the reload edge, then shifts right every 2 clocks. 0000001 is reached after 6 ticks; wrap on the 7th tick, back to 1000000.
- mode=10, div=0 -> lit index is 0,1,2,3,4,5,6,5,4,3,2,1,0. Index 6 holds for exactly 1 tick; wrap on the 12th tick only.
- mode=11, div=2 -> led changes every 3 clocks: 00,01,03,07,0F,1F,3F,7F,00. wrap only at the 7F->00 transition; step pulses are 3 clocks apart.
- mode=00, div=3: at led=0000100 with cnt=2, hold en=0 for 10 clocks -> led and cnt frozen, no step. After en=1, the next tick comes 2 clocks later -> led=0001000.
- mode=00 at led=0010000, switch mode to 01 -> next edge gives led=1000000, cnt=0, step=0, wrap=0. With div=0, the following edge gives 0100000 with step=1.

Source files
------------

// File: rtl/led_chaser_n.sv
// Parametrised LED chaser: rotate left/right, bounce and bar-fill patterns
// stepped by a programmable prescaler, with step and wrap strobes.
module led_chaser_n #(
  parameter int N_LEDS = 7,
  parameter int DIV_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [1:0]        mode,
  input  logic [DIV_W-1:0]  div,
  output logic [N_LEDS-1:0] led,
  output logic              step,
  output logic              wrap
);

  localparam int LW = $clog2(N_LEDS + 1);

  typedef enum logic [1:0] {
    MODE_ROL    = 2'b00,
    MODE_ROR    = 2'b01,
    MODE_BOUNCE = 2'b10,
    MODE_FILL   = 2'b11
  } mode_t;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

  mode_t             mode_q, mode_d, mode_in;
  dir_t              dir, dir_d, adv_dir;
  logic [DIV_W-1:0]  cnt, cnt_d;
  logic [LW-1:0]     level, level_d, adv_level;
  logic [N_LEDS-1:0] led_d, adv_led;
  logic              step_d, wrap_d;

  function automatic logic [N_LEDS-1:0] start_pattern(input mode_t m);
    logic [N_LEDS-1:0] p;
    p = '0;
    case (m)
      MODE_ROL, MODE_BOUNCE: p[0] = 1'b1;
      MODE_ROR:              p[N_LEDS-1] = 1'b1;
      default:               p = '0;
    endcase
    return p;
  endfunction

  function automatic logic [N_LEDS-1:0] thermometer(input logic [LW-1:0] lvl);
    logic [N_LEDS-1:0] t;
    for (int i = 0; i < N_LEDS; i++) t[i] = (i < int'(lvl));
    return t;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_q <= MODE_ROL;
      led    <= {{(N_LEDS-1){1'b0}}, 1'b1};
      cnt    <= '0;
      dir    <= DIR_UP;
      level  <= '0;
      step   <= 1'b0;
      wrap   <= 1'b0;
    end else begin
      mode_q <= mode_d;
      led    <= led_d;
      cnt    <= cnt_d;
      dir    <= dir_d;
      level  <= level_d;
      step   <= step_d;
      wrap   <= wrap_d;
    end
  end

  // Candidate next pattern for the current mode, used only on a tick.
  always_comb begin
    adv_led   = led;
    adv_dir   = dir;
    adv_level = level;
    case (mode_q)
      MODE_ROL: adv_led = {led[N_LEDS-2:0], led[N_LEDS-1]};
      MODE_ROR: adv_led = {led[0], led[N_LEDS-1:1]};
      MODE_BOUNCE: begin
        if (dir == DIR_UP) begin
          adv_led = led << 1;
          if (adv_led[N_LEDS-1]) adv_dir = DIR_DOWN;
        end else begin
          adv_led = led >> 1;
          if (adv_led[0]) adv_dir = DIR_UP;
        end
      end
      MODE_FILL: begin
        adv_level = (level == LW'(N_LEDS)) ? '0 : level + 1'b1;
        adv_led   = thermometer(adv_level);
      end
      default: adv_led = led;
    endcase
  end

  // A mode change reloads everything and beats both en and the prescaler.
  always_comb begin
    mode_in = mode_t'(mode);
    mode_d  = mode_q;
    led_d   = led;
    cnt_d   = cnt;
    dir_d   = dir;
    level_d = level;
    step_d  = 1'b0;
    wrap_d  = 1'b0;
    if (mode_in != mode_q) begin
      mode_d  = mode_in;
      led_d   = start_pattern(mode_in);
      cnt_d   = '0;
      dir_d   = DIR_UP;
      level_d = '0;
    end else if (en) begin
      if (cnt >= div) begin
        cnt_d   = '0;
        led_d   = adv_led;
        dir_d   = adv_dir;
        level_d = adv_level;
        step_d  = 1'b1;
        wrap_d  = (adv_led == start_pattern(mode_q));
      end else begin
        cnt_d = cnt + 1'b1;
      end
    end
  end

endmodule
